// File: rtl/frame_mem_arbiter_if.sv
// Requester-side bus of the frame memory arbiter: VGA reads, HPS writes, coprocessor reads.
// master = requester side, slave = arbiter side.
interface frame_mem_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              hps_req;
    logic [ADDR_W-1:0] hps_addr;
    logic [DATA_W-1:0] hps_wdata;
    logic              hps_gnt;

    logic              cop_req;
    logic [ADDR_W-1:0] cop_addr;
    logic              cop_gnt;
    logic              cop_rvalid;
    logic [DATA_W-1:0] cop_rdata;

    modport master (
        output vga_req, vga_addr, hps_req, hps_addr, hps_wdata, cop_req, cop_addr,
        input  vga_gnt, vga_rvalid, vga_rdata, hps_gnt, cop_gnt, cop_rvalid, cop_rdata
    );

    modport slave (
        input  vga_req, vga_addr, hps_req, hps_addr, hps_wdata, cop_req, cop_addr,
        output vga_gnt, vga_rvalid, vga_rdata, hps_gnt, cop_gnt, cop_rvalid, cop_rdata
    );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Shares one single-port frame memory between VGA (strict priority), HPS writes and coprocessor reads.
// Define FRAME_MEM_ARB_RR_EN to alternate HPS/coprocessor; without it HPS always beats the coprocessor.
module frame_mem_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 19200
) (
    input  logic               clk,
    input  logic               reset,
    frame_mem_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wren,
    output logic [DATA_W-1:0]  mem_data,
    input  logic [DATA_W-1:0]  mem_q,
    output logic               oor_err,
    output logic               idle
);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    logic              vga_gnt;
    logic              hps_gnt;
    logic              cop_gnt;
    logic              any_gnt;
    logic              hps_first;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_wren_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic              oor_err_reg;

    logic              s1_valid_reg, s1_cop_reg, s1_oor_reg;
    logic              s2_valid_reg, s2_cop_reg, s2_oor_reg;
    logic              vga_rvalid_reg, cop_rvalid_reg;
    logic [DATA_W-1:0] vga_rdata_reg, cop_rdata_reg;

`ifdef FRAME_MEM_ARB_RR_EN
    // Set when HPS should win the next HPS/coprocessor tie; moves only on their accepts.
    logic favour_hps_reg;
    assign hps_first = favour_hps_reg || !bus.cop_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            favour_hps_reg <= 1'b1;
        end else if (hps_gnt) begin
            favour_hps_reg <= 1'b0;
        end else if (cop_gnt) begin
            favour_hps_reg <= 1'b1;
        end
    end
`else
    assign hps_first = 1'b1;
`endif

    always_comb begin
        vga_gnt  = 1'b0;
        hps_gnt  = 1'b0;
        cop_gnt  = 1'b0;
        sel_addr = bus.cop_addr;
        if (!reset) begin
            if (bus.vga_req) begin
                vga_gnt = 1'b1;
            end else if (bus.hps_req && hps_first) begin
                hps_gnt = 1'b1;
            end else if (bus.cop_req) begin
                cop_gnt = 1'b1;
            end
        end
        if (vga_gnt) begin
            sel_addr = bus.vga_addr;
        end else if (hps_gnt) begin
            sel_addr = bus.hps_addr;
        end
    end

    assign any_gnt = vga_gnt || hps_gnt || cop_gnt;
    assign sel_oor = (sel_addr >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_reg   <= '0;
            mem_wren_reg   <= 1'b0;
            mem_data_reg   <= '0;
            oor_err_reg    <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_cop_reg     <= 1'b0;
            s1_oor_reg     <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_cop_reg     <= 1'b0;
            s2_oor_reg     <= 1'b0;
            vga_rvalid_reg <= 1'b0;
            cop_rvalid_reg <= 1'b0;
            vga_rdata_reg  <= '0;
            cop_rdata_reg  <= '0;
        end else begin
            mem_wren_reg <= hps_gnt && !sel_oor;
            if (any_gnt) begin
                mem_addr_reg <= sel_addr;
            end
            if (hps_gnt) begin
                mem_data_reg <= bus.hps_wdata;
            end
            if (any_gnt && sel_oor) begin
                oor_err_reg <= 1'b1;
            end

            // Read tracking runs independently of the grant path, so a completion and a new accept can share a cycle.
            s1_valid_reg <= vga_gnt || cop_gnt;
            s1_cop_reg   <= cop_gnt;
            s1_oor_reg   <= sel_oor;
            s2_valid_reg <= s1_valid_reg;
            s2_cop_reg   <= s1_cop_reg;
            s2_oor_reg   <= s1_oor_reg;

            vga_rvalid_reg <= s2_valid_reg && !s2_cop_reg;
            cop_rvalid_reg <= s2_valid_reg && s2_cop_reg;
            if (s2_valid_reg && !s2_cop_reg) begin
                vga_rdata_reg <= s2_oor_reg ? '0 : mem_q;
            end
            if (s2_valid_reg && s2_cop_reg) begin
                cop_rdata_reg <= s2_oor_reg ? '0 : mem_q;
            end
        end
    end

    assign bus.vga_gnt    = vga_gnt;
    assign bus.hps_gnt    = hps_gnt;
    assign bus.cop_gnt    = cop_gnt;
    assign bus.vga_rvalid = vga_rvalid_reg;
    assign bus.vga_rdata  = vga_rdata_reg;
    assign bus.cop_rvalid = cop_rvalid_reg;
    assign bus.cop_rdata  = cop_rdata_reg;

    assign mem_addr = mem_addr_reg;
    assign mem_wren = mem_wren_reg;
    assign mem_data = mem_data_reg;
    assign oor_err  = oor_err_reg;
    assign idle     = !(bus.vga_req || bus.hps_req || bus.cop_req) && !s1_valid_reg && !s2_valid_reg;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (priority rules, memory array, read-return queue).
`timescale 1ns/1ps
module tb_frame_mem_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 19200;
    localparam int WIN    = 128;
`ifdef FRAME_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;
    logic              oor_err;
    logic              idle;

    logic              pre_we = 1'b0;
    logic [14:0]       pre_addr = '0;
    logic [7:0]        pre_data = '0;
    logic [7:0]        mem_arr [0:32767];
    logic [7:0]        ref_mem [0:WIN-1];

    int checks = 0;
    int failures = 0;

    frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    frame_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_wren (mem_wren),
        .mem_data (mem_data),
        .mem_q    (mem_q),
        .oor_err  (oor_err),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory; out-of-range reads return junk so masking to zero is visible.
    always @(posedge clk) begin
        if (pre_we) begin
            mem_arr[pre_addr] <= pre_data;
        end else if (mem_wren && mem_addr < 19'(DEPTH)) begin
            mem_arr[mem_addr[14:0]] <= mem_data;
        end
        mem_q <= (mem_addr < 19'(DEPTH)) ? mem_arr[mem_addr[14:0]] : 8'h5A;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.hps_req = 1'b0; bus.hps_addr = '0; bus.hps_wdata = '0;
        bus.cop_req = 1'b0; bus.cop_addr = '0;
    endtask

    // Loads the low window of the memory while the DUT is held in reset.
    task automatic preload();
        reset = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            pre_we   = 1'b1;
            pre_addr = 15'(i);
            pre_data = (i == 5) ? 8'hA7 : 8'($urandom);
            ref_mem[i] = pre_data;
            tick();
        end
        pre_we = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [18:0] rand_addr();
        case ($urandom_range(0, 11))
            0:       return 19'd19200;
            1:       return 19'd20000;
            2:       return 19'h7FFFF;
            default: return 19'($urandom_range(0, WIN - 1));
        endcase
    endfunction

    task automatic test_reset();
        checks++;
        if ({mem_wren, mem_addr, mem_data} !== 28'h0) begin
            failures++;
            $display("FAIL reset_mem act=%b/%h/%h exp=0/00000/00", mem_wren, mem_addr, mem_data);
        end
        checks++;
        if ({bus.vga_rvalid, bus.cop_rvalid, bus.vga_rdata, bus.cop_rdata} !== 18'h0) begin
            failures++;
            $display("FAIL reset_read act=%b%b/%h/%h exp=00/00/00", bus.vga_rvalid, bus.cop_rvalid, bus.vga_rdata, bus.cop_rdata);
        end
        checks++;
        if ({oor_err, idle} !== 2'b01) begin
            failures++;
            $display("FAIL reset_flags act=oor%b idle%b exp=oor0 idle1", oor_err, idle);
        end
        bus.vga_req = 1'b1; bus.hps_req = 1'b1; bus.cop_req = 1'b1;
        #1;
        checks++;
        if ({bus.vga_gnt, bus.hps_gnt, bus.cop_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gnt act=%b%b%b exp=000", bus.vga_gnt, bus.hps_gnt, bus.cop_gnt);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        $display("txn reset: outputs at reset values");
    endtask

    task automatic test_single_read();
        bus.cop_req = 1'b1; bus.cop_addr = 19'd5;
        #1;
        checks++;
        if ({bus.vga_gnt, bus.hps_gnt, bus.cop_gnt} !== 3'b001) begin
            failures++;
            $display("FAIL single_gnt act=%b%b%b exp=001", bus.vga_gnt, bus.hps_gnt, bus.cop_gnt);
        end
        tick();
        bus.cop_req = 1'b0;
        checks++;
        if ({mem_wren, mem_addr} !== {1'b0, 19'd5}) begin
            failures++;
            $display("FAIL single_addr act=%b/%0d exp=0/5", mem_wren, mem_addr);
        end
        tick();
        checks++;
        if (bus.cop_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_early act=%b exp=0", bus.cop_rvalid);
        end
        tick();
        checks++;
        if ({bus.cop_rvalid, bus.vga_rvalid, bus.cop_rdata} !== {1'b1, 1'b0, 8'hA7}) begin
            failures++;
            $display("FAIL single_data act=c%b v%b %h exp=c1 v0 a7", bus.cop_rvalid, bus.vga_rvalid, bus.cop_rdata);
        end
        tick();
        checks++;
        if ({bus.cop_rvalid, bus.cop_rdata} !== {1'b0, 8'hA7}) begin
            failures++;
            $display("FAIL single_hold act=%b/%h exp=0/a7", bus.cop_rvalid, bus.cop_rdata);
        end
        $display("txn cop read addr=5 data=%h", bus.cop_rdata);
    endtask

    task automatic test_contention();
        logic [2:0] got [5];
        logic [2:0] want [5];
        want[0] = 3'b100; want[1] = 3'b010; want[2] = 3'b001; want[3] = 3'b010;
        want[4] = RR ? 3'b001 : 3'b010;
        bus.vga_req = 1'b1; bus.vga_addr = 19'd10;
        bus.hps_req = 1'b1; bus.hps_addr = 19'd50; bus.hps_wdata = 8'h11;
        bus.cop_req = 1'b1; bus.cop_addr = 19'd60;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) bus.vga_req = 1'b0;
            if (c == 2) bus.hps_req = 1'b0;
            if (c == 3) begin bus.hps_req = 1'b1; bus.hps_addr = 19'd51; end
            #1;
            got[c] = {bus.vga_gnt, bus.hps_gnt, bus.cop_gnt};
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (got[c] !== want[c]) begin
                failures++;
                $display("FAIL contention_c%0d act=%b exp=%b", c, got[c], want[c]);
            end
            $display("txn contention cycle %0d grant vga/hps/cop=%b", c, got[c]);
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_write_read();
        bus.hps_req = 1'b1; bus.hps_addr = 19'd100; bus.hps_wdata = 8'h3C;
        #1;
        checks++;
        if (bus.hps_gnt !== 1'b1) begin
            failures++;
            $display("FAIL wr_gnt act=%b exp=1", bus.hps_gnt);
        end
        tick();
        bus.hps_req = 1'b0;
        bus.cop_req = 1'b1; bus.cop_addr = 19'd100;
        checks++;
        if ({mem_wren, mem_addr, mem_data} !== {1'b1, 19'd100, 8'h3C}) begin
            failures++;
            $display("FAIL wr_mem act=%b/%0d/%h exp=1/100/3c", mem_wren, mem_addr, mem_data);
        end
        tick();
        bus.cop_req = 1'b0;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL wr_pulse act=%b exp=0", mem_wren);
        end
        tick();
        tick();
        checks++;
        if ({bus.cop_rvalid, bus.cop_rdata} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL wr_readback act=%b/%h exp=1/3c", bus.cop_rvalid, bus.cop_rdata);
        end
        $display("txn hps write 100=3c then cop read=%h", bus.cop_rdata);
    endtask

    task automatic test_out_of_range();
        do_reset();
        checks++;
        if (oor_err !== 1'b0) begin
            failures++;
            $display("FAIL oor_clear act=%b exp=0", oor_err);
        end
        bus.vga_req = 1'b1; bus.vga_addr = 19'd5;
        tick();
        bus.vga_req = 1'b0;
        tick(); tick();
        bus.hps_req = 1'b1; bus.hps_addr = 19'd19200; bus.hps_wdata = 8'hEE;
        #1;
        checks++;
        if (bus.hps_gnt !== 1'b1) begin
            failures++;
            $display("FAIL oor_wr_gnt act=%b exp=1", bus.hps_gnt);
        end
        tick();
        bus.hps_req = 1'b0;
        checks++;
        if ({mem_wren, oor_err} !== 2'b01) begin
            failures++;
            $display("FAIL oor_wr act=wren%b oor%b exp=wren0 oor1", mem_wren, oor_err);
        end
        bus.vga_req = 1'b1; bus.vga_addr = 19'd20000;
        tick();
        bus.vga_req = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.vga_rvalid, bus.vga_rdata, oor_err} !== {1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL oor_rd act=%b/%h/oor%b exp=1/00/oor1", bus.vga_rvalid, bus.vga_rdata, oor_err);
        end
        $display("txn oor write 19200 and vga read 20000 data=%h oor=%b", bus.vga_rdata, oor_err);
    endtask

    task automatic test_reset_midflight();
        bus.vga_req = 1'b1; bus.vga_addr = 19'd5;
        tick();
        bus.vga_req = 1'b0;
        tick(); tick();
        bus.vga_req = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.vga_gnt !== 1'b0) begin
            failures++;
            $display("FAIL mid_gnt act=%b exp=0", bus.vga_gnt);
        end
        tick();
        reset = 1'b0;
        bus.vga_req = 1'b0;
        #1;
        checks++;
        if ({mem_wren, mem_addr, mem_data, bus.vga_rvalid, bus.cop_rvalid, bus.vga_rdata, bus.cop_rdata, oor_err, idle}
                !== {28'h0, 18'h0, 2'b01}) begin
            failures++;
            $display("FAIL mid_reset act=%b/%h/%h/%b%b/%h/%h/%b%b exp=reset values", mem_wren, mem_addr, mem_data,
                     bus.vga_rvalid, bus.cop_rvalid, bus.vga_rdata, bus.cop_rdata, oor_err, idle);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.vga_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL mid_rvalid_c%0d act=%b exp=0", c, bus.vga_rvalid);
            end
        end
        $display("txn reset mid-flight: in-flight vga read dropped");
    endtask

    task automatic test_withdrawal();
        bus.vga_req = 1'b1; bus.vga_addr = 19'd7;
        bus.cop_req = 1'b1; bus.cop_addr = 19'd9;
        #1;
        checks++;
        if ({bus.vga_gnt, bus.hps_gnt, bus.cop_gnt} !== 3'b100) begin
            failures++;
            $display("FAIL wd_gnt act=%b%b%b exp=100", bus.vga_gnt, bus.hps_gnt, bus.cop_gnt);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (idle !== 1'b0) begin
            failures++;
            $display("FAIL wd_busy act=%b exp=0", idle);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.cop_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL wd_cop_rvalid_c%0d act=%b exp=0", c, bus.cop_rvalid);
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL wd_idle act=%b exp=1", idle);
        end
        $display("txn cop withdrawal: no transfer, idle=%b", idle);
    endtask

    task automatic test_random();
        bit          rq [3];
        logic [18:0] ra [3];
        logic [7:0]  wd;
        int          rate [3];
        bit          fav_hps, exp_oor, exp_wren, busy, oor, exp_vv, exp_cv;
        logic [7:0]  exp_vd, exp_cd;
        logic [18:0] exp_addr;
        int          due_q [$];
        bit          cop_q [$];
        logic [7:0]  dat_q [$];
        int          g, prev_g;
        rate[0] = 25; rate[1] = 50; rate[2] = 50;
        idle_inputs();
        preload();
        reset = 1'b0;
        fav_hps = 1'b1; exp_oor = 1'b0; exp_wren = 1'b0; exp_vd = 8'h00; exp_cd = 8'h00;
        exp_addr = 19'd0; prev_g = -1; wd = 8'h00;
        for (int i = 0; i < 3; i++) begin rq[i] = 1'b0; ra[i] = '0; end
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (rq[i] && i != prev_g) begin
                    if ($urandom_range(0, 19) == 0) rq[i] = 1'b0;
                end else begin
                    rq[i] = ($urandom_range(0, 99) < rate[i]);
                    ra[i] = rand_addr();
                    if (i == 1) wd = 8'($urandom);
                end
            end
            bus.vga_req = rq[0]; bus.vga_addr = ra[0];
            bus.hps_req = rq[1]; bus.hps_addr = ra[1]; bus.hps_wdata = wd;
            bus.cop_req = rq[2]; bus.cop_addr = ra[2];
            #1;
            if (rq[0])               g = 0;
            else if (rq[1] && rq[2]) g = (RR && !fav_hps) ? 2 : 1;
            else if (rq[1])          g = 1;
            else if (rq[2])          g = 2;
            else                     g = -1;
            busy = (due_q.size() > 0) && (due_q[0] <= n + 2);
            checks++;
            if ({bus.vga_gnt, bus.hps_gnt, bus.cop_gnt} !== {g == 0, g == 1, g == 2}) begin
                failures++;
                $display("FAIL rnd_gnt n=%0d act=%b%b%b exp=%b%b%b", n, bus.vga_gnt, bus.hps_gnt, bus.cop_gnt,
                         g == 0, g == 1, g == 2);
            end
            checks++;
            if (idle !== (!(rq[0] || rq[1] || rq[2]) && !busy)) begin
                failures++;
                $display("FAIL rnd_idle n=%0d act=%b exp=%b", n, idle, !(rq[0] || rq[1] || rq[2]) && !busy);
            end
            exp_wren = 1'b0;
            if (g >= 0) begin
                oor = (ra[g] >= 19'(DEPTH));
                exp_oor = exp_oor || oor;
                exp_addr = ra[g];
                if (g == 1) begin
                    fav_hps = 1'b0;
                    if (!oor) begin
                        exp_wren = 1'b1;
                        ref_mem[ra[g][6:0]] = wd;
                    end
                end else begin
                    if (g == 2) fav_hps = 1'b1;
                    due_q.push_back(n + 3);
                    cop_q.push_back(g == 2);
                    dat_q.push_back(oor ? 8'h00 : ref_mem[ra[g][6:0]]);
                end
                $display("txn rnd n=%0d id=%0d addr=%0d oor=%b", n, g, ra[g], oor);
            end
            prev_g = g;
            tick();
            exp_vv = 1'b0; exp_cv = 1'b0;
            if (due_q.size() > 0 && due_q[0] == n + 1) begin
                void'(due_q.pop_front());
                if (cop_q.pop_front()) begin exp_cv = 1'b1; exp_cd = dat_q.pop_front(); end
                else                   begin exp_vv = 1'b1; exp_vd = dat_q.pop_front(); end
            end
            checks++;
            if ({bus.vga_rvalid, bus.cop_rvalid, bus.vga_rdata, bus.cop_rdata} !== {exp_vv, exp_cv, exp_vd, exp_cd}) begin
                failures++;
                $display("FAIL rnd_read n=%0d act=%b%b/%h/%h exp=%b%b/%h/%h", n, bus.vga_rvalid, bus.cop_rvalid,
                         bus.vga_rdata, bus.cop_rdata, exp_vv, exp_cv, exp_vd, exp_cd);
            end
            checks++;
            if ({mem_wren, oor_err, mem_addr} !== {exp_wren, exp_oor, exp_addr}) begin
                failures++;
                $display("FAIL rnd_mem n=%0d act=wren%b oor%b addr%0d exp=wren%b oor%b addr%0d", n, mem_wren, oor_err,
                         mem_addr, exp_wren, exp_oor, exp_addr);
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        idle_inputs();
        preload();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_out_of_range();
        test_reset_midflight();
        test_withdrawal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
